ysyx_220066_icache: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the pipelined CPU core.
- Consumes the core fetch PC and produces `instr` / `instr_valid` / `instr_error`.
- A hit returns the instruction in the same cycle from register storage.
- A miss stalls the core (`instr_valid` = 0) while the FSM fetches one line from a single-outstanding-request, beat-counted memory port.

---
 rtl/ysyx_220066_icache_pkg.sv | 16 +
 rtl/ysyx_220066_icache_array.sv | 38 +++
 rtl/ysyx_220066_icache.sv | 107 ++++++++++
 tb/tb_ysyx_220066_icache.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_icache_pkg.sv
// ysyx_220066_icache_pkg: shared state encoding and address-split helpers for the instruction cache
package ysyx_220066_icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REFILL, ERR} state_t;
  function automatic int off_w(input int line_words);
    return $clog2(line_words * 8);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int pc_w, input int sets, input int line_words);
    return pc_w - off_w(line_words) - idx_w(sets);
  endfunction
  function automatic logic [63:0] line_addr(input logic [63:0] pc, input int off);
    return pc & ~((64'd1 << off) - 64'd1);
  endfunction
endpackage

// File: rtl/ysyx_220066_icache_array.sv
// ysyx_220066_icache_array: valid/tag/data register storage with async read and sync refill writes
module ysyx_220066_icache_array #(
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W = 55
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(SETS)-1:0]       rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [63:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [63:0]                   wr_data,
  input  logic                          tag_en,
  input  logic [TAG_W-1:0]              tag_in,
  input  logic                          tag_valid,
  input  logic                          inval
);
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [63:0]      data [SETS*LINE_WORDS];
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[{rd_idx, rd_word}];
  // invalidate wins over a same-edge line install
  always_ff @(posedge clk)
    if (!rst) valid <= '0;
    else if (inval) valid <= '0;
    else if (tag_en) valid[wr_idx] <= tag_valid;
  always_ff @(posedge clk) begin
    if (tag_en) tags[wr_idx] <= tag_in;
    if (wr_en) data[{wr_idx, wr_word}] <= wr_data;
  end
endmodule

// File: rtl/ysyx_220066_icache.sv
// ysyx_220066_icache: direct-mapped read-only instruction cache with single-outstanding line refill
module ysyx_220066_icache
  import ysyx_220066_icache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            instr_error,
  input  logic            fence_i,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [PC_W-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [63:0]     mem_rsp_data,
  input  logic            mem_rsp_err
);
  localparam int OFF = off_w(LINE_WORDS);
  localparam int IDX = idx_w(SETS);
  localparam int TAG = tag_w(PC_W, SETS, LINE_WORDS);
  localparam int CW  = $clog2(LINE_WORDS);
  state_t          state, next;
  logic [CW-1:0]   cnt;
  logic            err, kill;
  logic [PC_W-1:0] miss_addr, pc_line;
  logic            rd_valid, hit, misal, busy, beat, last, err_n;
  logic [TAG-1:0]  rd_tag;
  logic [63:0]     rd_data;
  assign pc_line      = PC_W'(line_addr(64'(pc), OFF));
  assign busy         = state == REQ || state == REFILL;
  assign beat         = state == REFILL && mem_rsp_valid;
  assign last         = beat && cnt == CW'(LINE_WORDS - 1);
  assign err_n        = err | mem_rsp_err;
  assign hit          = rd_valid && rd_tag == pc[PC_W-1:OFF+IDX];
  assign misal        = pc[1:0] != 2'b00;
  assign mem_req_addr = miss_addr;
  ysyx_220066_icache_array #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[OFF+IDX-1:OFF]),
    .rd_word   (pc[OFF-1:3]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (beat),
    .wr_idx    (miss_addr[OFF+IDX-1:OFF]),
    .wr_word   (cnt),
    .wr_data   (mem_rsp_data),
    .tag_en    (last),
    .tag_in    (miss_addr[PC_W-1:OFF+IDX]),
    .tag_valid (!kill && !err_n),
    .inval     (fence_i)
  );
  always_comb begin
    next          = state;
    instr_valid   = 1'b0;
    instr_error   = 1'b0;
    instr         = '0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        instr_valid = misal | hit;
        instr_error = misal;
        instr       = (misal | !hit) ? 32'h0 : (pc[2] ? rd_data[63:32] : rd_data[31:0]);
        next        = (misal | hit) ? IDLE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        next          = mem_req_ready ? REFILL : REQ;
      end
      REFILL: next = last ? (err_n ? ERR : IDLE) : REFILL;
      ERR: begin
        instr_valid = pc_line == miss_addr;
        instr_error = pc_line == miss_addr;
        next        = IDLE;
      end
      default: next = IDLE;
    endcase
    if (!rst) begin
      instr_valid   = 1'b0;
      instr_error   = 1'b0;
      instr         = '0;
      mem_req_valid = 1'b0;
    end
  end
  // kill remembers a fence seen while a fill is in flight so that fill is never validated
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      kill      <= 1'b0;
      miss_addr <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next == REQ) miss_addr <= pc_line;
      if (state == REQ) cnt <= '0;
      else if (beat) cnt <= cnt + 1'b1;
      err  <= (state == REFILL) ? (beat ? err_n : err) : 1'b0;
      kill <= busy & (kill | fence_i);
    end
endmodule

// File: tb/tb_ysyx_220066_icache.sv
// tb_ysyx_220066_icache: scoreboard bench driving fetches and a line-burst memory responder
module tb_ysyx_220066_icache;
  logic        clk = 0, rst = 0, fence_i = 0;
  logic        mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0;
  logic [63:0] pc = '0, mem_rsp_data = '0, mem_req_addr;
  logic [31:0] instr;
  logic        instr_valid, instr_error, mem_req_valid;
  int          total = 0, passed = 0;
  typedef struct packed {logic [31:0] instr; logic err; logic ci;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  ysyx_220066_icache dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .instr_error(instr_error), .fence_i(fence_i), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );
  function automatic logic [63:0] memw(input logic [63:0] a);
    return {a[31:0] ^ 32'h9111_0000, a[31:0] ^ 32'hA222_0000};
  endfunction
  function automatic logic [31:0] exp_instr(input logic [63:0] a);
    logic [63:0] w;
    w = memw({a[63:3], 3'b000});
    return a[2] ? w[63:32] : w[31:0];
  endfunction
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", t, got, exp);
    else passed++;
  endtask
  task automatic step(input logic [63:0] p, input logic f);
    @(negedge clk);
    pc = p;
    fence_i = f;
    #1;
  endtask
  task automatic push(input logic [63:0] p, input logic e, input logic ci);
    exp_t x;
    x.instr = e ? 32'h0 : exp_instr(p);
    x.err = e;
    x.ci = ci;
    q.push_back(x);
  endtask
  task automatic expect_out(input string t);
    exp_t e;
    chk({t, "_sb"}, 64'(q.size()), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({t, "_valid"}, 64'(instr_valid), 64'd1);
      chk({t, "_error"}, 64'(instr_error), 64'(e.err));
      if (e.ci) chk({t, "_instr"}, 64'(instr), 64'(e.instr));
    end
  endtask
  task automatic miss(input string t);
    chk({t, "_miss"}, 64'(instr_valid), 64'd0);
    chk({t, "_noreq"}, 64'(mem_req_valid), 64'd0);
  endtask
  task automatic refill(input logic [63:0] la, input int wait_n, input int err_b,
                        input bit fence_last, input logic [63:0] redir);
    for (int w = 0; w <= wait_n; w++) begin
      @(negedge clk);
      #1;
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_addr", mem_req_addr, la);
      chk("req_stall", 64'(instr_valid), 64'd0);
      mem_req_ready = (w == wait_n);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem_req_ready = 0;
      #1;
      chk("rf_noreq", 64'(mem_req_valid), 64'd0);
      chk("rf_stall", 64'(instr_valid), 64'd0);
      if (b == 1 && redir != 0) pc = redir;
      mem_rsp_valid = 1;
      mem_rsp_data = memw(la + 64'(8 * b));
      mem_rsp_err = (b == err_b);
      fence_i = fence_last && b == 3;
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = 0;
    mem_rsp_err = 0;
    fence_i = 0;
  endtask
  initial begin
    logic [63:0] hits [4] = '{64'h8000_0000, 64'h8000_000c, 64'h8000_0010, 64'h8000_001c};
    pc = 64'h8000_0002;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_error", 64'(instr_error), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_req", 64'(mem_req_valid), 64'd0);
    rst = 1;
    step(64'h8000_0004, 0);
    push(64'h8000_0004, 0, 1);
    miss("cold");
    refill(64'h8000_0000, 0, -1, 0, 0);
    step(64'h8000_0004, 0);
    expect_out("cold");
    foreach (hits[i]) begin
      step(hits[i], 0);
      push(hits[i], 0, 1);
      expect_out("hit");
      chk("hit_noreq", 64'(mem_req_valid), 64'd0);
    end
    step(64'h8000_0002, 0);
    push(64'h8000_0002, 1, 1);
    expect_out("misal");
    chk("misal_noreq", 64'(mem_req_valid), 64'd0);
    step(64'h8000_0003, 0);
    push(64'h8000_0003, 1, 1);
    expect_out("misal2");
    chk("misal_noreq2", 64'(mem_req_valid), 64'd0);
    step(64'h8000_0044, 0);
    push(64'h8000_0044, 0, 1);
    miss("bp");
    refill(64'h8000_0040, 3, -1, 0, 0);
    step(64'h8000_0044, 0);
    expect_out("bp");
    step(64'h8000_0004, 1);
    push(64'h8000_0004, 0, 1);
    expect_out("fence_pre");
    step(64'h8000_0010, 0);
    push(64'h8000_0010, 1, 0);
    miss("fence_post");
    refill(64'h8000_0000, 0, 2, 0, 0);
    step(64'h8000_0010, 0);
    expect_out("err");
    step(64'h8000_0010, 0);
    push(64'h8000_0010, 0, 1);
    miss("err_refetch");
    refill(64'h8000_0000, 0, -1, 1, 0);
    step(64'h8000_0010, 0);
    miss("fence_last");
    refill(64'h8000_0000, 0, -1, 0, 0);
    step(64'h8000_0010, 0);
    expect_out("refill_ok");
    step(64'h8000_0008, 1);
    push(64'h8000_0008, 0, 1);
    expect_out("fence2_pre");
    step(64'h8000_0000, 0);
    miss("redir");
    refill(64'h8000_0000, 0, -1, 0, 64'h8000_0100);
    step(64'h8000_0100, 0);
    push(64'h8000_0100, 0, 1);
    miss("redir_new");
    refill(64'h8000_0100, 0, -1, 0, 0);
    step(64'h8000_0100, 0);
    expect_out("redir_new");
    step(64'h8000_0000, 0);
    push(64'h8000_0000, 0, 1);
    expect_out("redir_old");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
